// File: rtl/key_sos_trigger_module.sv
// Push-button front end for a downstream SOS generator.
// A debounced press launches REPEAT start/done handshakes separated by idle gaps.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for a press; msg_cnt holds the previous press's total
// ST_REQ   | start_sig high, waiting for the done_sig pulse
// ST_GAP   | idle gap of GAP_CYCLES between two messages
module key_sos_trigger_module #(
  parameter int unsigned DB_CYCLES  = 1000000,
  parameter int unsigned GAP_CYCLES = 50000000,
  parameter int unsigned REPEAT     = 3
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       key_in,
  input  logic       done_sig,
  output logic       start_sig,
  output logic       busy,
  output logic [3:0] msg_cnt
);

  // The debounce counter only reaches DB_CYCLES-1; the gap timer counts down from GAP_CYCLES-1.
  localparam int unsigned DB_W  = (DB_CYCLES > 1)  ? $clog2(DB_CYCLES)  : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       REP_N    = 4'(REPEAT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  logic             key_meta_q;
  logic             key_sync_q;
  logic [DB_W-1:0]  db_cnt_q;
  logic [DB_W-1:0]  db_cnt_d;
  logic             stable_q;
  logic             stable_d;
  logic             press_q;
  logic             press_d;
  state_t           state_q;
  logic             start_q;
  logic             busy_q;
  logic [3:0]       msg_cnt_q;
  logic [3:0]       msg_inc;
  logic [GAP_W-1:0] gap_cnt_q;

  assign msg_inc = msg_cnt_q + 4'd1;

  // Two-flop synchronizer; resets to the released (high) level.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
    end else begin
      key_meta_q <= key_in;
      key_sync_q <= key_meta_q;
    end
  end

  // Debounce next state: accept a new level after DB_CYCLES consecutive differing samples.
  always_comb begin
    db_cnt_d = db_cnt_q;
    stable_d = stable_q;
    press_d  = 1'b0;
    if (key_sync_q == stable_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_cnt_d = '0;
      stable_d = key_sync_q;
      // Only a 1->0 acceptance is a press; release is silent.
      press_d  = ~key_sync_q;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  // Debounce registers; press_q is high in the same cycle stable_q first reads 0.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      db_cnt_q <= '0;
      stable_q <= 1'b1;
      press_q  <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
    end
  end

  // Message sequencer with registered outputs.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      msg_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Presses are only seen here, so presses while busy are dropped.
          if (press_q) begin
            state_q   <= ST_REQ;
            start_q   <= 1'b1;
            busy_q    <= 1'b1;
            msg_cnt_q <= '0;
          end
        end
        ST_REQ: begin
          if (done_sig) begin
            msg_cnt_q <= msg_inc;
            start_q   <= 1'b0;
            if (msg_inc < REP_N) begin
              state_q   <= ST_GAP;
              gap_cnt_q <= GAP_LAST;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == '0) begin
            state_q <= ST_REQ;
            start_q <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          start_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign start_sig = start_q;
  assign busy      = busy_q;
  assign msg_cnt   = msg_cnt_q;

endmodule

// File: tb/tb_key_sos_trigger_module.sv
// Scoreboard bench: stimulus pushes expected output events, a monitor pops
// them whenever {start_sig, busy, msg_cnt} changes.
module tb_key_sos_trigger_module;

  localparam int DB  = 4;
  localparam int GAP = 10;
  localparam int REP = 3;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       key_in;
  logic       done_sig;
  logic       start_sig;
  logic       busy;
  logic [3:0] msg_cnt;

  logic       key2;
  logic       done2;
  logic       start2;
  logic       busy2;
  logic [3:0] msg2;

  key_sos_trigger_module #(.DB_CYCLES(DB), .GAP_CYCLES(GAP), .REPEAT(REP)) dut (
    .CLK(CLK), .RSTn(RSTn), .key_in(key_in), .done_sig(done_sig),
    .start_sig(start_sig), .busy(busy), .msg_cnt(msg_cnt)
  );

  key_sos_trigger_module #(.DB_CYCLES(DB), .GAP_CYCLES(GAP), .REPEAT(1)) dut1 (
    .CLK(CLK), .RSTn(RSTn), .key_in(key2), .done_sig(done2),
    .start_sig(start2), .busy(busy2), .msg_cnt(msg2)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       s;
    logic       b;
    logic [3:0] m;
  } ev_t;

  ev_t expq[$];
  int  dq[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_pause = 1'b1;
  bit  idle_req = 1'b0;
  bit  gap_pulse_en = 1'b0;
  int  exp_msg = 0;
  int  rcnt = -1;
  int  xcnt = -1;
  logic sp = 1'b0;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output change must match the next expected event.
  initial begin
    logic [5:0] prev;
    logic [5:0] cur;
    ev_t e;
    prev = 6'd0;
    forever begin
      @(posedge CLK);
      #1;
      cur = {start_sig, busy, msg_cnt};
      if (cur !== prev && !mon_pause) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got s=%0b b=%0b m=%0d expected no change at cycle %0d",
                   start_sig, busy, msg_cnt, cyc);
        end else begin
          e = expq.pop_front();
          chk("event_cycle", cyc, e.cyc);
          chk("event_outputs", {26'd0, cur}, {26'd0, e.s, e.b, e.m});
        end
      end
      prev = cur;
    end
  end

  // Downstream responder: done_sig d cycles after each start rise, plus optional stray pulses.
  initial begin
    done_sig = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      done_sig = 1'b0;
      if (!RSTn) begin
        rcnt = -1;
        xcnt = -1;
        idle_req = 1'b0;
      end else begin
        if (idle_req) begin
          done_sig = 1'b1;
          idle_req = 1'b0;
        end
        if (xcnt > 0) begin
          xcnt--;
          if (xcnt == 0) begin
            done_sig = 1'b1;
            xcnt = -1;
          end
        end
        if (start_sig && !sp) begin
          rcnt = (dq.size() > 0) ? dq.pop_front() : 2;
        end else if (rcnt > 0) begin
          rcnt--;
          if (rcnt == 0) begin
            done_sig = 1'b1;
            rcnt = -1;
            if (gap_pulse_en) xcnt = 3;
          end
        end
      end
      sp = start_sig;
    end
  end

  task automatic wait_drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending events expected 0", expq.size());
      expq.delete();
    end
    dq.delete();
  endtask

  // A press accepted from IDLE: start rises DB+3 cycles after key_in is driven
  // low (2 sync flops, DB samples, 1 cycle press->start), then REP windows.
  task automatic press(input int len, input bit second);
    int c0;
    int r;
    int f;
    int d;
    c0 = cyc;
    key_in = 1'b0;
    r = c0 + DB + 3;
    for (int k = 1; k <= REP; k++) begin
      d = $urandom_range(1, 8);
      dq.push_back(d);
      expq.push_back('{r, 1'b1, 1'b1, 4'(k - 1)});
      f = r + d + 1;
      expq.push_back('{f, 1'b0, (k < REP), 4'(k)});
      r = f + GAP;
    end
    exp_msg = REP;
    tick(len);
    key_in = 1'b1;
    if (second) begin
      tick(DB + 3);
      key_in = 1'b0;
      tick(DB + 3);
      key_in = 1'b1;
    end
    wait_drain();
    tick(DB + 6);
  endtask

  task automatic bounce();
    for (int i = 0; i < 10; i++) begin
      key_in = 1'b0;
      tick(2);
      key_in = 1'b1;
      tick(1);
    end
    idle_req = 1'b1;
    tick(30);
    chk("bounce_start", {31'd0, start_sig}, 32'd0);
    chk("bounce_busy", {31'd0, busy}, 32'd0);
    chk("idle_msg_hold", {28'd0, msg_cnt}, exp_msg);
  endtask

  task automatic reset_mid_req();
    int c0;
    int r;
    int f;
    c0 = cyc;
    key_in = 1'b0;
    dq.push_back(3);
    dq.push_back(6);
    r = c0 + DB + 3;
    expq.push_back('{r, 1'b1, 1'b1, 4'd0});
    f = r + 4;
    expq.push_back('{f, 1'b0, 1'b1, 4'd1});
    expq.push_back('{f + GAP, 1'b1, 1'b1, 4'd1});
    tick(DB + 1);
    key_in = 1'b1;
    while (expq.size() != 0 && cyc < f + GAP + 20) tick();
    tick(2);
    chk("second_req_active", {31'd0, start_sig}, 32'd1);
    mon_pause = 1'b1;
    #2;
    RSTn = 1'b0;
    #1;
    chk("rst_start", {31'd0, start_sig}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_msg", {28'd0, msg_cnt}, 32'd0);
    expq.delete();
    dq.delete();
    tick(3);
    RSTn = 1'b1;
    tick(2);
    mon_pause = 1'b0;
    exp_msg = 0;
    tick(28);
    chk("post_rst_start", {31'd0, start_sig}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic single_repeat();
    int c0;
    int n;
    int rises;
    logic p;
    chk("r1_idle_start", {31'd0, start2}, 32'd0);
    c0 = cyc;
    key2 = 1'b0;
    n = 0;
    while (start2 !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (n == DB + 1) key2 = 1'b1;
    end
    key2 = 1'b1;
    chk("r1_rise_cycle", cyc, c0 + DB + 3);
    chk("r1_rise_busy", {31'd0, busy2}, 32'd1);
    tick(2);
    done2 = 1'b1;
    tick();
    done2 = 1'b0;
    chk("r1_end_start", {31'd0, start2}, 32'd0);
    chk("r1_end_busy", {31'd0, busy2}, 32'd0);
    chk("r1_end_msg", {28'd0, msg2}, 32'd1);
    rises = 0;
    p = start2;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (start2 && !p) rises++;
      p = start2;
    end
    chk("r1_no_more_windows", rises, 32'd0);
    chk("r1_msg_hold", {28'd0, msg2}, 32'd1);
  endtask

  initial begin
    RSTn = 1'b0;
    key_in = 1'b1;
    key2 = 1'b1;
    done2 = 1'b0;
    #3;
    chk("reset_start", {31'd0, start_sig}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_msg", {28'd0, msg_cnt}, 32'd0);
    tick(3);
    RSTn = 1'b1;
    tick(2);
    mon_pause = 1'b0;

    press(20, 1'b0);
    bounce();
    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 3))
        0: press($urandom_range(DB + 1, 20), 1'b0);
        1: press($urandom_range(DB + 1, DB + 4), 1'b1);
        2: bounce();
        default: begin
          gap_pulse_en = 1'b1;
          press($urandom_range(DB + 1, 20), 1'b0);
          gap_pulse_en = 1'b0;
        end
      endcase
    end
    press(DB + 2, 1'b1);
    reset_mid_req();
    single_repeat();
    wait_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
